// File: rtl/wireframe_scanout.sv
// Frame buffer scan-out: walks the wireframe buffer row-major and streams 1-bit pixels with eol/eof.
// Optional `CLEAR_ON_READ_EN adds a clear port that zeroes each pixel one cycle after it is read.
module wireframe_scanout #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned HEIGHT = 3,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_data,
  output logic              pix_eol,
  output logic              pix_eof,
  output logic              busy,
  output logic              done
`ifdef CLEAR_ON_READ_EN
  ,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              clr_data
`endif
);

  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(HEIGHT - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(WIDTH * HEIGHT - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              inflight_q, tag_eol_q, tag_eof_q, done_q;
  logic [1:0]        occ_q, occ_d;
  // Skid entries hold {data, eol, eof}; ent0 is the head.
  logic [2:0]        ent0_q, ent0_d, ent1_q, ent1_d;
  logic              pop, issue_eol, issue_eof;

  assign pix_valid = (occ_q != 2'd0);
  assign pix_data  = ent0_q[2];
  assign pix_eol   = ent0_q[1];
  assign pix_eof   = ent0_q[0];
  assign pop       = pix_valid & pix_ready;
  assign busy      = (state_q == StRun) || (state_q == StDrain);
  assign done      = done_q;
  assign issue_eol = (col_q == COL_LAST);
  assign issue_eof = issue_eol && (row_q == ROW_LAST);

  // Only issue when the skid is guaranteed a free slot once the read returns.
  assign rd_en   = (state_q == StRun) &&
                   (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign rd_addr = rd_en ? addr_q : '0;

  always_comb begin
    occ_d  = occ_q;
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    if (pop) begin
      ent0_d = ent1_q;
      occ_d  = occ_q - 2'd1;
    end
    if (inflight_q) begin
      if (occ_d == 2'd0) ent0_d = {rd_data, tag_eol_q, tag_eof_q};
      else               ent1_d = {rd_data, tag_eol_q, tag_eof_q};
      occ_d = occ_d + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      col_q      <= '0;
      row_q      <= '0;
      inflight_q <= 1'b0;
      tag_eol_q  <= 1'b0;
      tag_eof_q  <= 1'b0;
      done_q     <= 1'b0;
      occ_q      <= 2'd0;
      ent0_q     <= 3'd0;
      ent1_q     <= 3'd0;
    end else begin
      occ_q      <= occ_d;
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      inflight_q <= rd_en;
      tag_eol_q  <= issue_eol;
      tag_eof_q  <= issue_eof;
      done_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StRun;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
          end
        end
        StRun: begin
          if (rd_en) begin
            addr_q <= addr_q + 1'b1;
            if (issue_eol) begin
              col_q <= '0;
              row_q <= row_q + 1'b1;
            end else begin
              col_q <= col_q + 1'b1;
            end
            if (addr_q == ADDR_LAST) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (pop && pix_eof) begin
            state_q <= StDone;
            done_q  <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef CLEAR_ON_READ_EN
  logic              clr_en_q;
  logic [ADDR_W-1:0] clr_addr_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      clr_en_q   <= 1'b0;
      clr_addr_q <= '0;
    end else begin
      clr_en_q   <= rd_en;
      clr_addr_q <= rd_addr;
    end
  end

  assign clr_en   = clr_en_q;
  assign clr_addr = clr_addr_q;
  assign clr_data = 1'b0;
`endif

endmodule

// File: tb/tb_wireframe_scanout.sv
// Bench for wireframe_scanout (4x3 frame): frame-level pixel model checked every cycle
// plus directed scenarios with literal expectations.
module tb_wireframe_scanout;
  localparam int W = 4;
  localparam int H = 3;
  localparam int N = W * H;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic       n_rst, start, rd_en, rd_data, pix_valid, pix_ready;
  logic       pix_data, pix_eol, pix_eof, busy, done;
  logic [3:0] rd_addr;
`ifdef CLEAR_ON_READ_EN
  logic       clr_en, clr_data;
  logic [3:0] clr_addr;
`endif

  wireframe_scanout #(.WIDTH(W), .HEIGHT(H), .ADDR_W(4)) dut (
    .clk       (tb_clk),
    .n_rst     (n_rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .pix_valid (pix_valid),
    .pix_ready (pix_ready),
    .pix_data  (pix_data),
    .pix_eol   (pix_eol),
    .pix_eof   (pix_eof),
    .busy      (busy),
    .done      (done)
`ifdef CLEAR_ON_READ_EN
    ,
    .clr_en    (clr_en),
    .clr_addr  (clr_addr),
    .clr_data  (clr_data)
`endif
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame buffer model: 1-cycle read latency, optional clear port, bulk load from stimulus.
  logic [11:0] mem;
  logic [11:0] load_val;
  logic        load = 1'b0;
  always @(posedge tb_clk) begin
    if (load) mem <= load_val;
    if (rd_en) rd_data <= (rd_addr < 4'd12) ? mem[rd_addr] : 1'b0;
`ifdef CLEAR_ON_READ_EN
    if (clr_en && clr_addr < 4'd12) mem[clr_addr] <= clr_data;
`endif
  end

  // Expected image for the frame being scanned.
  logic [11:0] img;

  // Model/scoreboard state (written only by the compare process).
  int issued = 0, iss_lag = 0, popped = 0, negcnt = 0;
  int start_neg = -1, done_neg = -1, first_valid_neg = -1, last_done_neg = -1;
  int rd_after_done = -1, done_cnt = 0, cap_n = 0, rd_cnt = 0, valid_cnt = 0, clr_cnt = 0;
  int rd_log [16];
  logic [11:0] cap_data = '0, cap_eol = '0, cap_eof = '0;
  logic done_exp = 1'b0, prev_stall = 1'b0, prev_rd_en = 1'b0, pop_m;
  logic [2:0] prev_out = '0;
  logic [3:0] prev_rd_addr = '0;
  logic [15:0] quiet;

  always @(negedge tb_clk) begin
    negcnt++;
    if (!n_rst) begin
      quiet = {4'd0, rd_en, rd_addr, pix_valid, pix_data, pix_eol, pix_eof, busy, done, 1'b0};
`ifdef CLEAR_ON_READ_EN
      quiet[0] = clr_en;
`endif
      check("reset_outputs", 32'(quiet), 32'd0);
      issued = 0; iss_lag = 0; popped = 0;
      done_exp = 1'b0; prev_stall = 1'b0; prev_rd_en = 1'b0;
    end else begin
      if (start && !busy && !done) begin
        cap_data = '0; cap_eol = '0; cap_eof = '0; cap_n = 0; rd_cnt = 0;
        valid_cnt = 0; clr_cnt = 0; start_neg = negcnt; done_neg = -1; first_valid_neg = -1;
      end
      if (rd_en) begin
        check("rd_addr", 32'(rd_addr), 32'(issued));
        check("rd_in_frame", 32'(issued < N), 32'd1);
        if (rd_cnt < 16) rd_log[rd_cnt] = int'(rd_addr);
        rd_cnt++;
        if (rd_after_done < 0) rd_after_done = negcnt;
      end else begin
        check("rd_addr_idle", 32'(rd_addr), 32'd0);
      end
      // A read issued in cycle c is visible at the output from cycle c+2.
      check("skid_bound", 32'((iss_lag - popped) <= 2), 32'd1);
      check("pix_valid", 32'(pix_valid), 32'(iss_lag > popped));
      if (prev_stall)
        check("stall_hold", 32'({pix_valid, pix_data, pix_eol, pix_eof}), 32'({1'b1, prev_out}));
      if (pix_valid) begin
        valid_cnt++;
        if (first_valid_neg < 0) first_valid_neg = negcnt;
      end
      check("done", 32'(done), 32'(done_exp));
      pop_m = pix_valid && pix_ready;
      done_exp = pop_m && (popped == N - 1);
      if (pop_m) begin
        check("pop_in_frame", 32'(popped < N), 32'd1);
        if (popped < N) begin
          check("pix_data", 32'(pix_data), 32'(img[popped]));
          check("pix_eol", 32'(pix_eol), 32'((popped % W) == W - 1));
          check("pix_eof", 32'(pix_eof), 32'(popped == N - 1));
          cap_data[popped] = pix_data;
          cap_eol[popped]  = pix_eol;
          cap_eof[popped]  = pix_eof;
        end
        cap_n++;
        popped++;
      end
`ifdef CLEAR_ON_READ_EN
      check("clr_en", 32'(clr_en), 32'(prev_rd_en));
      if (clr_en) begin
        check("clr_addr", 32'(clr_addr), 32'(prev_rd_addr));
        check("clr_data", 32'(clr_data), 32'd0);
        clr_cnt++;
      end
`endif
      prev_stall   = pix_valid && !pix_ready;
      prev_out     = {pix_data, pix_eol, pix_eof};
      iss_lag      = issued;
      if (rd_en) issued++;
      prev_rd_en   = rd_en;
      prev_rd_addr = rd_addr;
      if (done) begin
        done_cnt++;
        if (done_neg < 0) done_neg = negcnt;
        last_done_neg = negcnt;
        rd_after_done = -1;
        issued = 0; iss_lag = 0; popped = 0;
      end
    end
  end

  task automatic load_mem(input logic [11:0] v);
    @(posedge tb_clk); #1;
    load_val = v;
    load = 1'b1;
    @(posedge tb_clk); #1;
    load = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge tb_clk); #1 start = 1'b1;
    @(posedge tb_clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int base;
    bit seen;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(posedge tb_clk);
      if (done_cnt > base) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input string name, input logic [11:0] exp_img);
    check({name, "_count"}, 32'(cap_n), 32'd12);
    check({name, "_data"}, 32'(cap_data), 32'(exp_img));
    check({name, "_eol"}, 32'(cap_eol), 32'h888);
    check({name, "_eof"}, 32'(cap_eof), 32'h800);
  endtask

  initial begin
    int base;
    logic [3:0] pat;
    bit seen;
    n_rst = 1'b0; start = 1'b0; pix_ready = 1'b1; img = 12'hA5C;
    load_mem(12'hA5C);
    repeat (2) @(posedge tb_clk);
    #1;
    check("reset_state", 32'({rd_en, pix_valid, busy, done}), 32'd0);
    n_rst = 1'b1;

    // Full-rate frame.
    pulse_start();
    wait_done(40, "a_done_timeout");
    check_frame("a", 12'hA5C);
    check("a_done_cycle", 32'(done_neg - start_neg), 32'd15);
    check("a_first_valid", 32'(first_valid_neg - start_neg), 32'd3);
    check("a_valid_cycles", 32'(valid_cnt), 32'd12);

    // Ready toggling 1,0,0,1.
    pat = 4'b1001;
    @(posedge tb_clk); #1 start = 1'b1;
    base = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge tb_clk); #1;
      start = 1'b0;
      pix_ready = pat[3 - (i % 4)];
      if (done_cnt > base) seen = 1'b1;
    end
    check("b_done_timeout", 32'(seen), 32'd1);
    check_frame("b", 12'hA5C);
    pix_ready = 1'b1;

    // Backpressure from the start.
    @(posedge tb_clk); #1 pix_ready = 1'b0;
    pulse_start();
    repeat (9) @(posedge tb_clk);
    check("c_reads_stalled", 32'(rd_cnt), 32'd2);
    check("c_addr0", 32'(rd_log[0]), 32'd0);
    check("c_addr1", 32'(rd_log[1]), 32'd1);
    #1 pix_ready = 1'b1;
    wait_done(40, "c_done_timeout");
    check("c_resume_addr", 32'(rd_log[2]), 32'd2);
    check_frame("c", 12'hA5C);

    // Reset after 5 handshakes.
    pulse_start();
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(posedge tb_clk);
      if (cap_n >= 5) seen = 1'b1;
    end
    check("d_five_pixels", 32'(seen), 32'd1);
    #1 n_rst = 1'b0;
    #1 check("d_async_reset", 32'({rd_en, rd_addr, pix_valid, pix_data, pix_eol, pix_eof, busy, done}),
             32'd0);
    base = done_cnt;
    repeat (3) @(posedge tb_clk);
    check("d_no_done", 32'(done_cnt), 32'(base));
    #1 n_rst = 1'b1;
    pulse_start();
    wait_done(40, "d_done_timeout");
    check_frame("d", 12'hA5C);

    // Start during RUN held through DONE.
    pulse_start();
    repeat (4) @(posedge tb_clk);
    #1 start = 1'b1;
    wait_done(40, "e_done_timeout");
    check_frame("e1", 12'hA5C);
    @(posedge tb_clk); #1 start = 1'b0;
    repeat (2) @(posedge tb_clk);
    check("e_restart_gap", 32'(rd_after_done - last_done_neg), 32'd2);
    wait_done(40, "e2_done_timeout");
    check_frame("e2", 12'hA5C);

`ifdef CLEAR_ON_READ_EN
    load_mem(12'hFFF);
    img = 12'hFFF;
    pulse_start();
    wait_done(40, "f_done_timeout");
    check_frame("f1", 12'hFFF);
    check("f_clear_count", 32'(clr_cnt), 32'd12);
    repeat (2) @(posedge tb_clk);
    check("f_mem_zero", 32'(mem), 32'd0);
    img = 12'h000;
    pulse_start();
    wait_done(40, "f2_done_timeout");
    check_frame("f2", 12'h000);
`endif

    repeat (3) @(posedge tb_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/wireframe_scanout.md
Name: wireframe_scanout

Overview:
- Reader side of the wireframe frame buffer. The rasterizer writes 1-bit pixels into this buffer through write_en/addr/wf_data.
- On start, walks the buffer in row-major order, issuing 1-cycle-latency reads, and streams pixels out over a valid/ready interface with end-of-line and end-of-frame markers.
- Feeds the display/serializer path. A 2-entry skid buffer absorbs backpressure against the read latency.

Parameters:
- WIDTH, `WIDTH, pixels per row
- HEIGHT, `HEIGHT, rows per frame
- ADDR_W, `WIREFRAME_ADDR_SIZE, frame buffer address width; must satisfy 2**ADDR_W >= WIDTH*HEIGHT

Ports:
- clk  in  1  system clock, rising edge
- n_rst  in  1  asynchronous active-low reset
- start  in  1  begin scanning one frame; sampled only in IDLE
- rd_en  out  1  frame buffer read strobe
- rd_addr  out  ADDR_W  read address, row*WIDTH+col
- rd_data  in  1  read data, valid exactly 1 cycle after rd_en
- pix_valid  out  1  output pixel valid
- pix_ready  in  1  downstream accepts pixel
- pix_data  out  1  pixel value
- pix_eol  out  1  pixel is last of its row (col==WIDTH-1)
- pix_eof  out  1  pixel is last of frame
- busy  out  1  high in RUN or DRAIN
- done  out  1  one-cycle pulse after the last pixel handshake

Behaviour:
- Reset: all outputs 0. State IDLE. Address counter 0. Skid buffer empty. In-flight read flag cleared; any rd_data returning after reset is discarded.
- States:
  - IDLE: start=1 -> RUN, next cycle. Counters are zeroed on entry to RUN.
  - RUN: issues reads. After the read of address WIDTH*HEIGHT-1 is issued -> DRAIN.
  - DRAIN: no reads issued. After the handshake (pix_valid&pix_ready) of the eof pixel -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
- start is ignored outside IDLE. start held high in IDLE triggers a new frame on the cycle after DONE.
- Read issue rule in RUN: rd_en=1 when occ + inflight - pop < 2.
  - occ = skid entries (0..2).
  - inflight = rd_en registered from the previous cycle.
  - pop = pix_valid&pix_ready this cycle.
  - rd_en is combinational from registered state plus pix_ready.
  - Guarantees no overflow. Sustains 1 pixel/cycle when pix_ready stays high.
- Address counter: increments by 1 per issued read. rd_addr = counter, rd_addr=0 when rd_en=0. Row/col counters track the issued address: col wraps WIDTH-1 -> 0 and increments row.
- eol/eof tags: computed at issue, delayed 1 cycle alongside the read, stored in the skid entry with the data.
- Capture: the cycle after rd_en, {rd_data, eol, eof} is pushed to the skid buffer tail.
- Output: pix_valid = occ != 0. pix_data/pix_eol/pix_eof come from the head entry.
- Skid buffer operations:
  - Simultaneous push and pop: occ unchanged, order preserved.
  - Pop with occ=1 and no push: occ becomes 0.
  - Push with occ=2 is impossible by the issue rule; verification asserts this.
- Latency: first pix_valid appears 2 cycles after start is sampled (RUN entry +1 read +1 capture).
- With pix_ready=1 continuously, a frame takes WIDTH*HEIGHT+3 cycles from start to done.
- Outputs hold stable while pix_valid=1 and pix_ready=0.
- Reset mid-frame: immediate return to IDLE, no done pulse, skid cleared.
- WIDTH*HEIGHT==1: the single pixel carries eol=1 and eof=1.

Optional Feature:
- CLEAR_ON_READ_EN defined: adds ports clr_en (out,1), clr_addr (out,ADDR_W) and clr_data (out,1, always 0).
  - clr_en asserts the cycle after each rd_en, with clr_addr equal to the previous rd_addr.
  - Each pixel is erased as it is scanned, leaving the buffer zeroed for the next rasterizer pass.
  - clr_en is 0 in reset and IDLE. A reset during the capture cycle suppresses that clear.
- Undefined: ports absent; the buffer is untouched.

Test Plan:
- Bench settings: WIDTH=4, HEIGHT=3. Model memory is 12 bits with 1-cycle read latency.
- Memory 0xA5C (bit i at addr i), pix_ready=1, start pulse -> 12 pixels in addr order 0..11 matching the memory bits; eol on pixels 3, 7, 11; eof only on pixel 11; pix_valid continuous; done exactly 15 cycles after start sampled.
- Same frame, pix_ready toggled 1,0,0,1 repeating -> identical pixel sequence, no drop or duplicate; outputs stable during ready=0; skid never overflows (assertion).
- pix_ready=0 from start for 10 cycles -> exactly 2 reads issued (addr 0, 1), then rd_en=0; after ready rises, stream resumes at addr 2.
- Assert n_rst after 5 pixels handshaked -> all outputs 0 immediately; no done; next start restarts at addr 0 and eof arrives on pixel 11.
- start pulsed during RUN and held high through DONE -> mid-frame start ignored; second frame begins the cycle after done.
- With CLEAR_ON_READ_EN: after one frame of 0xFFF -> clr_en seen 12 times with addrs 0..11, each one cycle after the matching read; memory reads all-zero; a second frame outputs 12 zeros.
